// File: rtl/car_power_ctrl_pkg.sv
// Shared power-state and off-cause encodings for the car power controller
// and the display/status logic that decodes off_cause.
package car_power_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF_ARMED = 2'd0,
      ON_HOLD   = 2'd1,
      ON        = 2'd2,
      OFF_LOCK  = 2'd3
   } pwr_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_BUTTON  = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } off_cause_e;

endpackage

// File: rtl/car_power_ctrl_idle_timer.sv
// Inactivity counter: counts consecutive idle cycles while enabled and
// raises expire combinationally in the terminal-count cycle.
module idle_timer #(
   parameter int unsigned IDLE_TIMEOUT = 100_000_000,
   parameter int unsigned CNT_W        = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic expire
);

   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(IDLE_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign expire = en && !restart && (cnt == TERMINAL);

   // Clearing on expire keeps the counter from ever wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || restart || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/car_power_ctrl.sv
// Car power-state FSM: owns the authoritative power state, one-cycle on/off
// event pulses and the last power-off cause.
module car_power_ctrl
   import car_power_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 100_000_000,
   parameter int unsigned CNT_W        = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power_on,
   input  logic       power_off_btn,
   input  logic       activity,
   output logic       power_state,
   output logic       on_pulse,
   output logic       off_pulse,
   output logic [1:0] off_cause
);

   pwr_state_e state, state_nxt;
   off_cause_e cause_q, cause_nxt;
   logic       power_nxt;
   logic       on_nxt;
   logic       off_nxt;
   logic       expire;

   idle_timer #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .CNT_W        (CNT_W)
   ) u_idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state == ON),
      .restart (activity),
      .expire  (expire)
   );

   always_comb begin
      state_nxt = state;
      cause_nxt = cause_q;
      case (state)
         OFF_ARMED: begin
            if (power_on && !power_off_btn) state_nxt = ON_HOLD;
         end
         ON_HOLD: begin
            if (power_off_btn) begin
               state_nxt = OFF_LOCK;
               cause_nxt = CAUSE_BUTTON;
            end else if (!power_on) begin
               state_nxt = ON;
            end
         end
         ON: begin
            if (power_off_btn) begin
               state_nxt = OFF_LOCK;
               cause_nxt = CAUSE_BUTTON;
            end else if (expire) begin
               state_nxt = OFF_LOCK;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         OFF_LOCK: begin
            if (!power_on && !power_off_btn) state_nxt = OFF_ARMED;
         end
         default: state_nxt = OFF_ARMED;
      endcase

      // Outputs are derived from the transition so they register with the state.
      power_nxt = (state_nxt == ON_HOLD) || (state_nxt == ON);
      on_nxt    = (state == OFF_ARMED) && (state_nxt == ON_HOLD);
      off_nxt   = (state != OFF_LOCK) && (state_nxt == OFF_LOCK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= OFF_ARMED;
         cause_q     <= CAUSE_NONE;
         power_state <= 1'b0;
         on_pulse    <= 1'b0;
         off_pulse   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cause_q     <= cause_nxt;
         power_state <= power_nxt;
         on_pulse    <= on_nxt;
         off_pulse   <= off_nxt;
      end
   end

   assign off_cause = cause_q;

endmodule

// File: tb/tb_car_power_ctrl.sv
// Scoreboard bench for car_power_ctrl: directed scenarios plus random
// stimulus against a behavioural power model.
module tb_car_power_ctrl;

   localparam int unsigned T = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       power_on = 1'b0;
   logic       power_off_btn = 1'b0;
   logic       activity = 1'b0;
   logic       power_state;
   logic       on_pulse;
   logic       off_pulse;
   logic [1:0] off_cause;

   car_power_ctrl #(
      .IDLE_TIMEOUT (T),
      .CNT_W        (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .power_on      (power_on),
      .power_off_btn (power_off_btn),
      .activity      (activity),
      .power_state   (power_state),
      .on_pulse      (on_pulse),
      .off_pulse     (off_pulse),
      .off_cause     (off_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic [4:0]  val;   // {power_state, on_pulse, off_pulse, off_cause}
   } sb_t;

   sb_t         sb_q[$];
   int unsigned cyc_n = 0;
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Behavioural model: powered flag, lockout until release, hold-until-release
   // after power-up, and a count of consecutive idle cycles once running.
   bit         m_pw, m_lock, m_held;
   int         m_idle;
   logic [1:0] m_cause;

   task automatic model_reset();
      m_pw = 0; m_lock = 0; m_held = 0; m_idle = 0; m_cause = 2'b00;
   endtask

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got ps/on/off/cause=%b required %b", name, cyc_n, act, exp);
   endtask

   task automatic model_step(input logic on, input logic btn, input logic act);
      bit  onp;
      bit  offp;
      sb_t e;
      onp = 0;
      offp = 0;
      if (!m_pw) begin
         if (m_lock) begin
            if (!on && !btn) m_lock = 0;
         end else if (on && !btn) begin
            m_pw = 1; m_held = 1; onp = 1;
         end
      end else if (btn) begin
         m_pw = 0; m_lock = 1; m_cause = 2'b01; offp = 1;
      end else if (m_held) begin
         if (!on) begin m_held = 0; m_idle = 0; end
      end else if (act) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle >= int'(T)) begin
            m_pw = 0; m_lock = 1; m_cause = 2'b10; offp = 1;
         end
      end
      e.due = cyc_n + 1;
      e.val = {m_pw, onp, offp, m_cause};
      sb_q.push_back(e);
   endtask

   // Drive inputs for the next rising edge and queue the expected result.
   task automatic cyc(input logic on, input logic btn, input logic act);
      @(posedge clk);
      #2;
      power_on = on;
      power_off_btn = btn;
      activity = act;
      model_step(on, btn, act);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #6;
      rst_n = 1'b0;
      #1;
      check("reset_async", {power_state, on_pulse, off_pulse, off_cause}, 5'b0);
      sb_q.delete();
      model_reset();
      power_on = 0; power_off_btn = 0; activity = 0;
      repeat (2) @(posedge clk);
      #6;
      rst_n = 1'b1;
   endtask

   // Monitor: compares DUT outputs after each edge with the due queue entry.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #4;
         if (rst_n && sb_q.size() > 0 && sb_q[0].due == cyc_n) begin
            e = sb_q.pop_front();
            check("cycle", {power_state, on_pulse, off_pulse, off_cause}, e.val);
         end
      end
   end

   initial begin
      model_reset();
      #3;
      check("reset_state", {power_state, on_pulse, off_pulse, off_cause}, 5'b0);
      @(posedge clk);
      #6;
      rst_n = 1'b1;

      // Power on with a 3-cycle hold, then run.
      repeat (3) cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 0);
      // Button off from ON.
      cyc(0, 1, 0);
      repeat (2) cyc(0, 0, 0);
      // Idle timeout.
      cyc(1, 0, 0);
      repeat (12) cyc(0, 0, 0);
      // Activity every 7 cycles keeps it on, then button off.
      cyc(1, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, (i % 7) == 6);
      cyc(0, 1, 0);
      repeat (2) cyc(0, 0, 0);
      // Button beats power_on in OFF_ARMED.
      repeat (2) cyc(1, 1, 0);
      repeat (2) cyc(0, 0, 0);
      // Button on the terminal-count cycle.
      cyc(1, 0, 0);
      repeat (8) cyc(0, 0, 0);
      cyc(0, 1, 0);
      repeat (2) cyc(0, 0, 0);
      // power_on held across a button off stays locked; release then re-power.
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 1, 0);
      repeat (3) cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      repeat (3) cyc(0, 0, 1);
      // Reset while ON.
      mid_reset();
      repeat (2) cyc(0, 0, 0);

      for (int i = 0; i < 1500; i++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 11) == 0);
         if ($urandom_range(0, 399) == 0) mid_reset();
      end

      repeat (2) @(posedge clk);
      #6;
      check("queue_drained", 5'(sb_q.size()), 5'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
